// File: rtl/matrix_pkg.sv
`default_nettype none
//-----------------------------------------------------------------------------
// Module   : matrix_pkg
// Brief    : Shared state encoding, widths and colour-compare helper for the
//            LED matrix scan driver.
// Revision : 1.0
//-----------------------------------------------------------------------------
package matrix_pkg;

   localparam int ADDR_W  = 5;
   localparam int COLOR_W = 8;

   typedef enum logic [1:0] {
      SHIFT_LO = 2'd0,
      SHIFT_HI = 2'd1,
      BLANK    = 2'd2,
      LATCH    = 2'd3
   } state_t;

   // One bit per channel: lit when the channel intensity beats the PWM level.
   function automatic logic [2:0] color_bits(input logic [3*COLOR_W-1:0] px,
                                             input logic [COLOR_W-1:0]   level);
      color_bits = {px[3*COLOR_W-1 -: COLOR_W] > level,
                    px[2*COLOR_W-1 -: COLOR_W] > level,
                    px[COLOR_W-1   -: COLOR_W] > level};
   endfunction

endpackage
`default_nettype wire

// File: rtl/tick_divider.sv
`default_nettype none
//-----------------------------------------------------------------------------
// Module   : tick_divider
// Brief    : Free-running 0..divider-1 counter; tick high for the last count.
// Revision : 1.0
//-----------------------------------------------------------------------------
module tick_divider #(
   parameter int divider = 3
) (
   input  logic clk,
   input  logic reset,
   output logic tick
);

   localparam int                 c_CNT_W = $clog2(divider);
   localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(divider - 1);

   logic [c_CNT_W-1:0] r_count;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_count <= '0;
      end else if (tick) begin
         r_count <= '0;
      end else begin
         r_count <= r_count + 1'b1;
      end
   end

   assign tick = (r_count == c_LAST);

endmodule
`default_nettype wire

// File: rtl/matrix_test.sv
`default_nettype none
//-----------------------------------------------------------------------------
// Module   : matrix_test
// Brief    : HUB75-style LED matrix scan driver with row scan and global PWM.
// Revision : 1.0
//-----------------------------------------------------------------------------
module matrix_test
   import matrix_pkg::*;
#(
   parameter int divider  = 3,
   parameter int length   = 32,
   parameter int scan_bit = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   output logic [ADDR_W-1:0]      addr,
   input  logic [3*COLOR_W-1:0]   data1,
   input  logic [3*COLOR_W-1:0]   data2,
   output logic [2:0]             rgb1,
   output logic [2:0]             rgb2,
   output logic                   sclk,
   output logic                   latch,
   output logic                   oe_b,
   output logic [scan_bit-1:0]    select
);

   localparam logic [ADDR_W-1:0] c_LAST_COL = ADDR_W'(length - 1);

   state_t              r_state;
   logic [ADDR_W-1:0]   r_addr;
   logic [2:0]          r_rgb1;
   logic [2:0]          r_rgb2;
   logic                r_sclk;
   logic                r_latch;
   logic                r_oe_b;
   logic [scan_bit-1:0] r_row;
   logic [scan_bit-1:0] r_select;
   logic [COLOR_W-1:0]  r_pwm;
   logic                w_tick;

   tick_divider #(
      .divider (divider)
   ) u_tick (
      .clk   (clk),
      .reset (reset),
      .tick  (w_tick)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state  <= SHIFT_LO;
         r_addr   <= '0;
         r_rgb1   <= '0;
         r_rgb2   <= '0;
         r_sclk   <= 1'b0;
         r_latch  <= 1'b0;
         r_oe_b   <= 1'b1;
         r_row    <= '0;
         r_select <= '0;
         r_pwm    <= '0;
      end else begin
         // Pixel data trails addr by one clk, so keep resampling for the whole low phase.
         if (r_state == SHIFT_LO) begin
            r_rgb1 <= color_bits(data1, r_pwm);
            r_rgb2 <= color_bits(data2, r_pwm);
         end
         if (w_tick) begin
            unique case (r_state)
               SHIFT_LO: begin
                  r_state <= SHIFT_HI;
                  r_sclk  <= 1'b1;
               end
               SHIFT_HI: begin
                  r_sclk <= 1'b0;
                  if (r_addr == c_LAST_COL) begin
                     r_state <= BLANK;
                     r_oe_b  <= 1'b1;
                  end else begin
                     r_state <= SHIFT_LO;
                     r_addr  <= r_addr + 1'b1;
                  end
               end
               BLANK: begin
                  r_state  <= LATCH;
                  r_latch  <= 1'b1;
                  r_select <= r_row;
               end
               LATCH: begin
                  r_state <= SHIFT_LO;
                  r_latch <= 1'b0;
                  r_oe_b  <= 1'b0;
                  r_addr  <= '0;
                  r_row   <= r_row + 1'b1;
                  if (&r_row) begin
                     r_pwm <= r_pwm + 1'b1;
                  end
               end
            endcase
         end
      end
   end

   assign addr   = r_addr;
   assign rgb1   = r_rgb1;
   assign rgb2   = r_rgb2;
   assign sclk   = r_sclk;
   assign latch  = r_latch;
   assign oe_b   = r_oe_b;
   assign select = r_select;

endmodule
`default_nettype wire

// File: tb/tb_matrix_test.sv
`default_nettype none
//-----------------------------------------------------------------------------
// Module   : tb_matrix_test
// Brief    : Directed self-checking bench for matrix_test (3 / 5 / 2 config).
// Revision : 1.0
//-----------------------------------------------------------------------------
module tb_matrix_test;

   localparam int DIV  = 3;
   localparam int LEN  = 5;
   localparam int SB   = 2;
   localparam int ROWS = 1 << SB;
   localparam int LINE = (2 * LEN + 2) * DIV;

   logic          clk   = 1'b0;
   logic          reset = 1'b1;
   logic [4:0]    addr;
   logic [23:0]   data1 = '0;
   logic [23:0]   data2 = '0;
   logic [2:0]    rgb1;
   logic [2:0]    rgb2;
   logic          sclk;
   logic          latch;
   logic          oe_b;
   logic [SB-1:0] select;

   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   int   rises  = 0;
   int   lat_clks = 0;
   logic prev_sclk = 1'b0;
   logic [2:0] prev_rgb1 = '0;

   matrix_test #(
      .divider  (DIV),
      .length   (LEN),
      .scan_bit (SB)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .addr   (addr),
      .data1  (data1),
      .data2  (data2),
      .rgb1   (rgb1),
      .rgb2   (rgb2),
      .sclk   (sclk),
      .latch  (latch),
      .oe_b   (oe_b),
      .select (select)
   );

   always #5 clk = ~clk;

   // Pixel source: one clk of latency from addr.
   always @(posedge clk) begin
      data1 <= {19'd0, addr};
      data2 <= ~{19'd0, addr};
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_reset_values();
      check("rst_addr",   32'(addr),   32'd0);
      check("rst_rgb1",   32'(rgb1),   32'd0);
      check("rst_rgb2",   32'(rgb2),   32'd0);
      check("rst_sclk",   32'(sclk),   32'd0);
      check("rst_latch",  32'(latch),  32'd0);
      check("rst_oe_b",   32'(oe_b),   32'd1);
      check("rst_select", 32'(select), 32'd0);
   endtask

   // Advance one clk and compare every output against the position in the line.
   task automatic step_and_check();
      int   ln, p, seg, col, pwm;
      logic exp_sclk, exp_latch, exp_oe;
      int   exp_addr, exp_sel;
      @(negedge clk);
      cyc++;
      ln  = cyc / LINE;
      p   = cyc % LINE;
      seg = p / DIV;
      col = seg / 2;
      pwm = ln / ROWS;
      exp_sclk  = (seg < 2 * LEN) && (seg % 2 == 1);
      exp_latch = (seg == 2 * LEN + 1);
      exp_oe    = (cyc < LINE) || (seg >= 2 * LEN);
      exp_addr  = (seg < 2 * LEN) ? col : LEN - 1;
      if (seg == 2 * LEN + 1) exp_sel = ln % ROWS;
      else if (ln == 0)       exp_sel = 0;
      else                    exp_sel = (ln - 1) % ROWS;
      check("sclk",   32'(sclk),   32'(exp_sclk));
      check("latch",  32'(latch),  32'(exp_latch));
      check("oe_b",   32'(oe_b),   32'(exp_oe));
      check("addr",   32'(addr),   32'(exp_addr));
      check("select", 32'(select), 32'(exp_sel));
      check("latch_and_sclk", 32'(latch & sclk), 32'd0);
      if (exp_sclk) begin
         check("rgb1", 32'(rgb1), (col > pwm) ? 32'd1 : 32'd0);
         check("rgb2", 32'(rgb2), 32'd7);
         if (!prev_sclk) check("rgb1_on_sclk_rise", 32'(rgb1), 32'(prev_rgb1));
      end
      if (sclk && !prev_sclk) rises++;
      if (latch) lat_clks++;
      prev_sclk = sclk;
      prev_rgb1 = rgb1;
   endtask

   task automatic run_lines(input int n);
      for (int l = 0; l < n; l++) begin
         rises    = 0;
         lat_clks = 0;
         for (int i = 0; i < LINE; i++) step_and_check();
         check("sclk_rises_per_line", 32'(rises), 32'(LEN));
         check("latch_clks_per_line", 32'(lat_clks), 32'(DIV));
      end
   endtask

   initial begin
      #2 reset = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_values();
      reset     = 1'b1;
      cyc       = 0;
      prev_sclk = 1'b0;

      // Six lines: select wraps 0..3 and pwm steps to 1 on the fifth line.
      run_lines(6);

      // Reach SHIFT_HI of column 1 in line 6, then pull reset asynchronously.
      repeat (10) step_and_check();
      check("pre_reset_sclk", 32'(sclk), 32'd1);
      #1 reset = 1'b0;
      #1 check_reset_values();
      repeat (2) @(negedge clk);
      check_reset_values();
      reset     = 1'b1;
      cyc       = 0;
      prev_sclk = 1'b0;
      run_lines(1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
